// File: rtl/frame_serializer_pkg.sv
// Shared types and constants for the frame serializer: FSM state encoding and field widths.
package frame_serializer_pkg;

    localparam int PORT_W = 2;
    localparam int NUM_W  = 4;
    localparam int DATA_W = 16;
    localparam logic GAP_BIT = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_PORT  = 3'd2,
        ST_NUM   = 3'd3,
        ST_GAP   = 3'd4,
        ST_DATA  = 3'd5
    } state_t;

endpackage

// File: rtl/frame_serializer_bit_counter.sv
// Loadable 4-bit down counter with enable and zero flag; saturates at zero.
module frame_bit_counter
    import frame_serializer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [NUM_W-1:0] load_val,
    output logic [NUM_W-1:0] count,
    output logic             zero
);

    logic [NUM_W-1:0] count_r;

    // Counter register: load has priority, otherwise decrement without wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {NUM_W{1'b0}};
        end else if (en) begin
            if (load) begin
                count_r <= load_val;
            end else if (count_r != {NUM_W{1'b0}}) begin
                count_r <= count_r - {{(NUM_W-1){1'b0}}, 1'b1};
            end else begin
                count_r <= count_r;
            end
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;
    assign zero  = (count_r == {NUM_W{1'b0}});

endmodule

// File: rtl/frame_serializer.sv
// Serialises a frame (start, port, num, gap, data MSB-first) one bit per clken edge.
module frame_serializer
    import frame_serializer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clken,
    input  logic              start,
    input  logic [PORT_W-1:0] port,
    input  logic [NUM_W-1:0]  num,
    input  logic [DATA_W-1:0] data,
    output logic              ready,
    output logic              serout,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t            state_r;
    state_t            state_next_s;
    logic              serout_r;
    logic              ser_next_s;
    logic              done_r;
    logic              err_r;
    logic [PORT_W-1:0] port_r;
    logic [NUM_W-1:0]  num_r;
    logic [DATA_W-1:0] data_r;

    logic              ready_s;
    logic              accept_s;
    logic              refuse_s;
    logic              cnt_load_s;
    logic              cnt_dec_s;
    logic [NUM_W-1:0]  cnt_load_val_s;
    logic [NUM_W-1:0]  cnt_s;
    logic              cnt_zero_s;
    logic [NUM_W-1:0]  cnt_m1_s;

    frame_bit_counter u_cnt (
        .clk      (clk),
        .rst      (rst),
        .en       (clken & (cnt_load_s | cnt_dec_s)),
        .load     (cnt_load_s),
        .load_val (cnt_load_val_s),
        .count    (cnt_s),
        .zero     (cnt_zero_s)
    );

    // The counter holds the index of the bit currently on the line within its field.
    assign cnt_m1_s = cnt_s - 4'd1;
    assign ready_s  = (state_r == ST_IDLE) || ((state_r == ST_DATA) && cnt_zero_s);
    assign accept_s = clken && start && ready_s && (num != 4'd0);
    assign refuse_s = clken && start && ready_s && (num == 4'd0);

    // Next state and next line value for the coming bit time.
    always_comb begin
        state_next_s   = state_r;
        ser_next_s     = serout_r;
        cnt_load_s     = 1'b0;
        cnt_dec_s      = 1'b0;
        cnt_load_val_s = 4'd0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_next_s = ST_START;
                    ser_next_s   = 1'b0;
                end else begin
                    ser_next_s   = 1'b1;
                end
            end
            ST_START: begin
                state_next_s   = ST_PORT;
                ser_next_s     = port_r[1];
                cnt_load_s     = 1'b1;
                cnt_load_val_s = 4'd1;
            end
            ST_PORT: begin
                if (cnt_zero_s) begin
                    state_next_s   = ST_NUM;
                    ser_next_s     = num_r[3];
                    cnt_load_s     = 1'b1;
                    cnt_load_val_s = 4'd3;
                end else begin
                    ser_next_s = port_r[0];
                    cnt_dec_s  = 1'b1;
                end
            end
            ST_NUM: begin
                if (cnt_zero_s) begin
                    state_next_s = ST_GAP;
                    ser_next_s   = GAP_BIT;
                end else begin
                    ser_next_s = num_r[cnt_m1_s[1:0]];
                    cnt_dec_s  = 1'b1;
                end
            end
            ST_GAP: begin
                state_next_s   = ST_DATA;
                ser_next_s     = data_r[num_r - 4'd1];
                cnt_load_s     = 1'b1;
                cnt_load_val_s = num_r - 4'd1;
            end
            ST_DATA: begin
                if (cnt_zero_s) begin
                    // Last data bit: chain straight into the next start bit if one is waiting.
                    if (accept_s) begin
                        state_next_s = ST_START;
                        ser_next_s   = 1'b0;
                    end else begin
                        state_next_s = ST_IDLE;
                        ser_next_s   = 1'b1;
                    end
                end else begin
                    ser_next_s = data_r[cnt_m1_s];
                    cnt_dec_s  = 1'b1;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                ser_next_s   = 1'b1;
            end
        endcase
    end

    // State, line and request capture advance on clken; done/err are single-clk pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            serout_r <= 1'b1;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            port_r   <= {PORT_W{1'b0}};
            num_r    <= {NUM_W{1'b0}};
            data_r   <= {DATA_W{1'b0}};
        end else begin
            done_r <= clken && (state_r == ST_DATA) && cnt_zero_s;
            err_r  <= refuse_s;
            if (clken) begin
                state_r  <= state_next_s;
                serout_r <= ser_next_s;
                if (accept_s) begin
                    port_r <= port;
                    num_r  <= num;
                    data_r <= data;
                end else begin
                    port_r <= port_r;
                    num_r  <= num_r;
                    data_r <= data_r;
                end
            end else begin
                state_r  <= state_r;
                serout_r <= serout_r;
            end
        end
    end

    assign ready  = ready_s;
    assign busy   = (state_r != ST_IDLE);
    assign serout = serout_r;
    assign done   = done_r;
    assign err    = err_r;

endmodule

// File: doc/frame_serializer.md
FRAME_SERIALIZER -- requirements
Module: frame_serializer

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have port clken, input, 1 bit: bit-time enable; state, counters and serout advance only on edges where clken=1.
REQ-004 The block SHALL have port start, input, 1 bit: frame request; accepted on an edge where start=1, ready=1 and clken=1.
REQ-005 The block SHALL have port port, input, 2 bits: destination port, sampled at accept.
REQ-006 The block SHALL have port num, input, 4 bits: data-bit count (1..15), sampled at accept.
REQ-007 The block SHALL have port data, input, 16 bits: payload; bits data[num-1:0] are sent, sampled at accept.
REQ-008 The block SHALL have port ready, output, 1 bit: high when a request can be accepted this edge.
REQ-009 The block SHALL have port serout, output, 1 bit, registered: serial line, idles 1.
REQ-010 The block SHALL have port busy, output, 1 bit: high while a frame is in progress (state not IDLE).
REQ-011 The block SHALL have port done, output, 1 bit: one-clk pulse after the last data bit has been driven.
REQ-012 The block SHALL have port err, output, 1 bit: one-clk pulse when a request with num=0 is refused.

Function
REQ-013 The block SHALL send each frame MSB-first as the following bit times: start bit 0; port[1:0]; num[3:0]; one gap bit of value 1 (the receiver's counter-load slot); then num data bits, data[num-1] down to data[0].
REQ-014 Frame length SHALL be 8+num bit times, with one bit per clken edge.
REQ-015 The FSM SHALL have the states IDLE, START, PORT, NUM, GAP and DATA.
REQ-016 The FSM SHALL make these transitions: IDLE->START on accept; START->PORT; PORT->NUM after 2 bits; NUM->GAP after 4 bits; GAP->DATA; DATA->IDLE after num bits.
REQ-017 ready SHALL be 1 in IDLE and during the last DATA bit time, and 0 otherwise.
REQ-018 An accept during the last DATA bit time SHALL go directly to START, so the next start bit follows the last data bit with no idle gap and no idle 1.
REQ-019 serout SHALL be driven 1 in IDLE.
REQ-020 Inputs SHALL be captured into internal registers at accept; later input changes SHALL NOT affect a frame in flight.
REQ-021 A request with num=0 SHALL NOT be accepted: the state is unchanged, err pulses for one clk, and serout stays 1.
REQ-022 Requests while ready=0 SHALL be ignored, and err SHALL stay 0 in that case.
REQ-023 done SHALL be asserted for exactly one clk, on the edge that leaves the last DATA bit time, including when back-to-back frames follow.
REQ-024 When clken=0, all registers SHALL hold their values; done and err SHALL still last only one clk.
REQ-025 The bit counter SHALL be 4 bits wide, loaded per field and decremented to 0; it SHALL NOT wrap past 0.

Reset
REQ-026 When rst=1 on a rising clk edge, the block SHALL go to IDLE regardless of clken, with serout=1, busy=0, done=0, err=0 and ready=1.
REQ-027 A reset during a frame SHALL abort the frame immediately, with the line returning to 1 on the next edge; no done pulse SHALL be produced.

Structure
REQ-028 A shared package SHALL hold the state encoding (3 bits) and the constants PORT_W=2, NUM_W=4, DATA_W=16 and GAP_BIT=1.
REQ-029 The block SHALL contain one sub-module, frame_bit_counter: a loadable 4-bit down counter with enable and a zero flag, used for the PORT, NUM and DATA fields.

Verification
REQ-030 Basic frame: port=2'b10, num=3, data=16'h0005 with clken=1 every cycle -> serout=0,1,0,0,0,1,1,1,1,0,1 and then 1; done pulses once after the 11th bit.
REQ-031 Back-to-back frames: a second request (port=2'b01, num=1, data=16'h0001) held during the last bit of the first frame -> its start bit 0 immediately follows, with no idle 1.
REQ-032 Refused request: num=0 -> err=1 for one clk, ready stays 1, serout stays 1, and busy stays 0.
REQ-033 Slow enable: clken pulsed every 4th clk with num=15 and data=16'h7FFF -> 23 bits, each held exactly 4 clks; done is 1 clk wide.
REQ-034 Reset mid-frame: rst during the NUM field -> serout=1 and ready=1 on the next edge, no done pulse, and a new frame is accepted afterwards.
REQ-035 Inputs changed after accept: port, num and data toggled mid-frame -> the transmitted frame matches the values captured at accept.
